udp_tx_frame_buffer: RTL and testbench

Store-and-forward frame buffer that sits directly upstream of the 10G UDP stack's user transmit port. It accepts application payload frames of unknown length and buffers each complete frame. It counts the frame's bytes, then replays the frame into the stack's s_axis_user_* port with the UDP payload length presented on tuser from the first beat. Frames that are oversize or empty are discarded and counted.

---
 rtl/udp_tx_buf_pkg.sv | 37 +++
 rtl/udp_tx_sdp_ram.sv | 27 ++
 rtl/udp_tx_frame_buffer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_udp_tx_frame_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_buf_pkg.sv
// Shared definitions for the UDP transmit frame buffer.
//   - write/read FSM state encodings
//   - width of the payload length field and of the internal byte counter
//   - popcount of an 8-bit keep and the saturating byte-count adder
package udp_tx_buf_pkg;

  localparam int LEN_W = 16;  // payload length field carried on tuser
  localparam int CNT_W = 11;  // internal byte counter, saturates at 2047

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_FRAME   = 2'd1,
    W_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_SEND = 2'd2
  } rd_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  // Saturating add keeps an oversize frame from wrapping back under the limit.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/udp_tx_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port
// (1-cycle read latency). Contents are not reset.
//   clk   : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module udp_tx_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 72,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_tx_frame_buffer.sv
// Store-and-forward frame buffer in front of the UDP stack user TX port.
// Buffers each complete application frame, counts its bytes, then replays it
// with the payload length on tuser from the first beat. Oversize (>P_MAX_BYTES)
// and empty frames are discarded and counted.
//   i_xgmii_clk / i_xgmii_rst : clock, async active-low reset
//   s_axis_app_*              : application payload in (byte 0 in [63:56])
//   m_axis_user_*             : to stack s_axis_user_*, tuser = {len, 16'h0}
//   o_frame_cnt / o_drop_cnt  : frames sent / frames discarded (wrap)
module udp_tx_frame_buffer
  import udp_tx_buf_pkg::*;
#(
  parameter int P_DATA_DEPTH = 512,
  parameter int P_LEN_DEPTH  = 16,
  parameter int P_MAX_BYTES  = 1472
) (
  input  logic        i_xgmii_clk,
  input  logic        i_xgmii_rst,
  input  logic [63:0] s_axis_app_data,
  input  logic [7:0]  s_axis_app_keep,
  input  logic        s_axis_app_last,
  input  logic        s_axis_app_valid,
  output logic        s_axis_app_ready,
  output logic [63:0] m_axis_user_data,
  output logic [31:0] m_axis_user_user,
  output logic [7:0]  m_axis_user_keep,
  output logic        m_axis_user_last,
  output logic        m_axis_user_valid,
  input  logic        m_axis_user_ready,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int AW  = $clog2(P_DATA_DEPTH);
  localparam int LAW = $clog2(P_LEN_DEPTH);
  localparam logic [AW:0]      RAM_FULL = (AW+1)'(P_DATA_DEPTH);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
  localparam logic [LAW:0]     LF_FULL  = (LAW+1)'(P_LEN_DEPTH);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(P_MAX_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // write side state
  wr_state_e        wr_state_q, wr_state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, frm_start_q, frm_start_d;
  logic [AW:0]      commit_ptr_q, commit_ptr_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             run_q;
  // length FIFO
  logic [LAW:0]     lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d;
  logic [CNT_W-1:0] lf_len_mem [P_LEN_DEPTH];
  logic [7:0]       lf_keep_mem [P_LEN_DEPTH];
  // read side state
  rd_state_e        rd_state_q, rd_state_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fetch_left_q, fetch_left_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [7:0]       frame_keep_q, frame_keep_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             rv_q, rv_d, rlast_q, rlast_d;
  // two-entry output stage
  logic [63:0]      ob_data_q [2];
  logic [63:0]      ob_data_d [2];
  logic [7:0]       ob_keep_q [2];
  logic [7:0]       ob_keep_d [2];
  logic [1:0]       ob_last_q, ob_last_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;
  logic             ob_head_q, ob_head_d;

  logic             app_acc, ram_we, lf_push, lf_pop, lf_full, lf_empty, ram_full;
  logic [CNT_W-1:0] cnt_base, cnt_sum, lf_len_rd, lf_beats;
  logic [7:0]       lf_keep_rd;
  logic             cnt_over, out_pop, rd_issue, ob_tail;
  logic [2:0]       ob_occ;
  logic [71:0]      ram_rdata;

  assign lf_full  = (lf_wp_q - lf_rp_q) == LF_FULL;
  assign lf_empty = (lf_wp_q == lf_rp_q);
  assign ram_full = (wr_ptr_q - rd_ptr_q) == RAM_FULL;

  assign s_axis_app_ready = run_q && ((wr_state_q == W_DISCARD) || (!lf_full && !ram_full));
  assign app_acc  = s_axis_app_valid && s_axis_app_ready;
  assign cnt_base = (wr_state_q == W_IDLE) ? '0 : byte_cnt_q;
  assign cnt_sum  = sat_add(cnt_base, popcount8(s_axis_app_keep));
  assign cnt_over = cnt_sum > MAX_CNT;

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    frm_start_d  = frm_start_q;
    commit_ptr_d = commit_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ram_we       = 1'b0;
    lf_push      = 1'b0;
    if (app_acc) begin
      if (wr_state_q == W_DISCARD) begin
        if (s_axis_app_last) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          wr_state_d = W_IDLE;
        end
      end else if (cnt_over) begin
        // Rewind so the RAM space of the oversize frame is reused.
        wr_ptr_d = frm_start_q;
        if (s_axis_app_last) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_DISCARD;
        end
      end else if (s_axis_app_last && (cnt_sum == '0)) begin
        wr_ptr_d   = frm_start_q;
        drop_cnt_d = drop_cnt_q + 16'd1;
        wr_state_d = W_IDLE;
      end else begin
        ram_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        byte_cnt_d = cnt_sum;
        wr_state_d = W_FRAME;
        if (s_axis_app_last) begin
          lf_push      = 1'b1;
          commit_ptr_d = wr_ptr_q + PTR_ONE;
          frm_start_d  = wr_ptr_q + PTR_ONE;
          wr_state_d   = W_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_xgmii_clk) begin
    if (lf_push) begin
      lf_len_mem[lf_wp_q[LAW-1:0]]  <= cnt_sum;
      lf_keep_mem[lf_wp_q[LAW-1:0]] <= s_axis_app_keep;
    end
  end

  assign lf_len_rd  = lf_len_mem[lf_rp_q[LAW-1:0]];
  assign lf_keep_rd = lf_keep_mem[lf_rp_q[LAW-1:0]];
  assign lf_beats   = CNT_W'(({1'b0, lf_len_rd} + (CNT_W+1)'(7)) >> 3);
  assign lf_wp_d    = lf_wp_q + (LAW+1)'(lf_push);
  assign lf_rp_d    = lf_rp_q + (LAW+1)'(lf_pop);

  // Issue a RAM read only if the output stage can absorb it after the
  // beat already in flight, counting the beat leaving this cycle.
  assign out_pop  = m_axis_user_valid && m_axis_user_ready;
  assign ob_occ   = {1'b0, ob_cnt_q} + {2'b00, rv_q} - {2'b00, out_pop};
  assign rd_issue = (rd_state_q != R_IDLE) && (fetch_left_q != '0) &&
                    (ob_occ < 3'd2) && (rd_ptr_q != commit_ptr_q);

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_left_d = fetch_left_q;
    frame_len_d  = frame_len_q;
    frame_keep_d = frame_keep_q;
    frame_cnt_d  = frame_cnt_q;
    rlast_d      = rlast_q;
    rv_d         = rd_issue;
    lf_pop       = 1'b0;
    case (rd_state_q)
      R_IDLE: if (!lf_empty) begin
        lf_pop       = 1'b1;
        frame_len_d  = LEN_W'(lf_len_rd);
        frame_keep_d = lf_keep_rd;
        fetch_left_d = lf_beats;
        rd_state_d   = R_LOAD;
      end
      R_LOAD: rd_state_d = R_SEND;
      R_SEND: if (out_pop && m_axis_user_last) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        rd_state_d  = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_issue) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      fetch_left_d = fetch_left_q - CNT_ONE;
      rlast_d      = (fetch_left_q == CNT_ONE);
    end
  end

  assign ob_tail = ob_head_q ^ ob_cnt_q[0];

  always_comb begin
    ob_data_d = ob_data_q;
    ob_keep_d = ob_keep_q;
    ob_last_d = ob_last_q;
    if (rv_q) begin
      ob_data_d[ob_tail] = ram_rdata[71:8];
      ob_keep_d[ob_tail] = rlast_q ? frame_keep_q : ram_rdata[7:0];
      ob_last_d[ob_tail] = rlast_q;
    end
    ob_cnt_d  = ob_cnt_q + {1'b0, rv_q} - {1'b0, out_pop};
    ob_head_d = ob_head_q ^ out_pop;
  end

  always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst) begin
    if (!i_xgmii_rst) begin
      wr_state_q   <= W_IDLE;
      wr_ptr_q     <= '0;
      frm_start_q  <= '0;
      commit_ptr_q <= '0;
      byte_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      run_q        <= 1'b0;
      lf_wp_q      <= '0;
      lf_rp_q      <= '0;
      rd_state_q   <= R_IDLE;
      rd_ptr_q     <= '0;
      fetch_left_q <= '0;
      frame_len_q  <= '0;
      frame_keep_q <= '0;
      frame_cnt_q  <= '0;
      rv_q         <= 1'b0;
      rlast_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ob_data_q[i] <= '0;
        ob_keep_q[i] <= '0;
      end
      ob_last_q    <= '0;
      ob_cnt_q     <= '0;
      ob_head_q    <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_ptr_q     <= wr_ptr_d;
      frm_start_q  <= frm_start_d;
      commit_ptr_q <= commit_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      run_q        <= 1'b1;
      lf_wp_q      <= lf_wp_d;
      lf_rp_q      <= lf_rp_d;
      rd_state_q   <= rd_state_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_left_q <= fetch_left_d;
      frame_len_q  <= frame_len_d;
      frame_keep_q <= frame_keep_d;
      frame_cnt_q  <= frame_cnt_d;
      rv_q         <= rv_d;
      rlast_q      <= rlast_d;
      ob_data_q    <= ob_data_d;
      ob_keep_q    <= ob_keep_d;
      ob_last_q    <= ob_last_d;
      ob_cnt_q     <= ob_cnt_d;
      ob_head_q    <= ob_head_d;
    end
  end

  udp_tx_sdp_ram #(.DEPTH(P_DATA_DEPTH), .W(72)) u_ram (
    .clk   (i_xgmii_clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis_app_data, s_axis_app_keep}),
    .re    (rd_issue),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign m_axis_user_valid = (ob_cnt_q != 2'd0);
  assign m_axis_user_data  = ob_data_q[ob_head_q];
  assign m_axis_user_keep  = ob_keep_q[ob_head_q];
  assign m_axis_user_last  = ob_last_q[ob_head_q];
  assign m_axis_user_user  = {frame_len_q, 16'h0000};
  assign o_frame_cnt       = frame_cnt_q;
  assign o_drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Scoreboard bench for udp_tx_frame_buffer: the driver queues the expected
// output beats of every frame it sends; an independent monitor pops and
// compares on each output handshake and checks stability while stalled.
module tb_udp_tx_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0, s_valid = 1'b0, s_ready;
  logic [63:0] m_data;
  logic [31:0] m_user;
  logic [7:0]  m_keep;
  logic        m_last, m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] frame_cnt, drop_cnt;

  always #5 clk = ~clk;

  udp_tx_frame_buffer dut (
    .i_xgmii_clk       (clk),
    .i_xgmii_rst       (rst_n),
    .s_axis_app_data   (s_data),
    .s_axis_app_keep   (s_keep),
    .s_axis_app_last   (s_last),
    .s_axis_app_valid  (s_valid),
    .s_axis_app_ready  (s_ready),
    .m_axis_user_data  (m_data),
    .m_axis_user_user  (m_user),
    .m_axis_user_keep  (m_keep),
    .m_axis_user_last  (m_last),
    .m_axis_user_valid (m_valid),
    .m_axis_user_ready (m_ready),
    .o_frame_cnt       (frame_cnt),
    .o_drop_cnt        (drop_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [31:0] u;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, last_acc_cyc = 0, rise_cyc = -100;
  int exp_frames = 0, exp_drops = 0;
  bit rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // output monitor / scoreboard
  initial begin : monitor
    beat_t e;
    logic held = 1'b0, prev_v = 1'b0;
    logic [63:0] hd;
    logic [40:0] hc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        prev_v = 1'b0;
        continue;
      end
      if (m_valid && !prev_v) rise_cyc = cyc;
      prev_v = m_valid;
      if (held) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hd);
        chk("stall_ctrl", {m_user, m_keep, m_last}, hc);
      end
      if (m_valid && m_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %h with no beat expected", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.d);
          chk("beat_keep", m_keep, e.k);
          chk("beat_last", m_last, e.l);
          chk("beat_user", m_user, e.u);
        end
      end else if (m_valid) begin
        held = 1'b1;
        hd = m_data;
        hc = {m_user, m_keep, m_last};
      end else begin
        held = 1'b0;
      end
    end
  end

  // 50% random output backpressure when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests expected completion", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    logic r;
    s_data = d;
    s_keep = k;
    s_last = l;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 20000);
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 20000 cycles");
    end
    last_acc_cyc = cyc;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  // nbytes == 0 sends a single empty last beat (keep 8'h00)
  task automatic send_frame(input int nbytes, input bit partial);
    int nb = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
    int rem = nbytes % 8;
    bit ok = (nbytes >= 1) && (nbytes <= 1472) && !partial;
    logic [7:0] lk;
    beat_t b[$];
    beat_t bt;
    lk = (nbytes == 0) ? 8'h00 : ((rem == 0) ? 8'hFF : 8'(8'hFF << (8 - rem)));
    for (int i = 0; i < nb; i++) begin
      bt.d = {$urandom, $urandom};
      bt.k = (i == nb - 1) ? lk : 8'hFF;
      bt.l = (i == nb - 1);
      bt.u = {nbytes[15:0], 16'h0000};
      b.push_back(bt);
      if (ok) exp_q.push_back(bt);
    end
    if (partial) begin
      for (int i = 0; i < nb; i++) send_beat(b[i].d, 8'hFF, 1'b0);
    end else begin
      for (int i = 0; i < nb; i++) send_beat(b[i].d, b[i].k, b[i].l);
      if (ok) exp_frames++;
      else exp_drops++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_app_ready"}, s_ready, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_user"}, m_user, 0);
    chk({tag, "_keep_last"}, {m_keep, m_last}, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    bit saw;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", s_ready, 1);

    // 100-byte frame: 13 beats, last keep F0, user 0x00640000, valid at N+3
    m_ready = 1'b1;
    send_frame(100, 0);
    wait_drain();
    chk("latency", rise_cyc - last_acc_cyc, 3);
    chk("frame_cnt_100B", frame_cnt, 1);
    chk("drop_cnt_100B", drop_cnt, 0);

    // oversize frames: overflow on the last beat, and mid-frame into discard
    send_frame(1480, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_cnt_1480B", drop_cnt, 1);
    send_frame(1600, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_cnt_1600B", drop_cnt, 2);
    chk("frame_cnt_after_drops", frame_cnt, 1);
    send_frame(8, 0);
    wait_drain();
    chk("frame_cnt_8B", frame_cnt, 2);

    // empty frame
    send_frame(0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_cnt_empty", drop_cnt, 3);

    // 20 x 64-byte frames with output blocked, then released
    m_ready = 1'b0;
    saw = 1'b0;
    fork
      for (int f = 0; f < 20; f++) send_frame(64, 0);
      begin
        for (int n = 0; n < 3000 && !saw; n++) begin
          @(negedge clk);
          if (s_valid && !s_ready) saw = 1'b1;
        end
        chk("app_backpressure", saw, 1);
        repeat (10) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();
    chk("frame_cnt_burst", frame_cnt, 22);

    // random lengths with random output backpressure
    rand_mode = 1'b1;
    for (int f = 0; f < 200; f++) send_frame(int'($urandom_range(1, 1472)), 0);
    wait_drain();
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    chk("frame_cnt_random", frame_cnt, exp_frames);
    chk("drop_cnt_random", drop_cnt, exp_drops);

    // reset while one frame is being sent and another is half written
    m_ready = 1'b0;
    send_frame(40, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_valid", m_valid, 1);
    send_frame(24, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_frame(16, 0);
    wait_drain();
    chk("frame_cnt_post_reset", frame_cnt, 1);
    chk("drop_cnt_post_reset", drop_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
